ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit_if.sv | 42 ++++
 rtl/ex_muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Bundles the ID/EX-side signals of the HI/LO multiply/divide unit.
//   master : the pipeline (drives the EX op, observes stall/results)
//   slave  : ex_muldiv_unit
//   Signals:
//     md_valid          ID/EX entry is a valid R-type op
//     funct_ID_EX       funct field of the op in EX
//     read_data1_ID_EX  rs operand
//     read_data2_ID_EX  rt operand
//     flush             kill the op currently in EX
//     stall             hold IF/ID/EX this cycle
//     md_busy           an iterative op is in flight
//     md_done           one-cycle pulse after HI/LO are written by mul/div
//     md_result         MFHI/MFLO data for the EX result mux
//     md_result_valid   md_result is valid this cycle
//     hi_out / lo_out   architectural HI / LO
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            md_valid;
    logic [5:0]      funct_ID_EX;
    logic [XLEN-1:0] read_data1_ID_EX;
    logic [XLEN-1:0] read_data2_ID_EX;
    logic            flush;
    logic            stall;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            md_result_valid;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;

    modport master (
        output md_valid, funct_ID_EX, read_data1_ID_EX, read_data2_ID_EX, flush,
        input  stall, md_busy, md_done, md_result, md_result_valid, hi_out, lo_out
    );

    modport slave (
        input  md_valid, funct_ID_EX, read_data1_ID_EX, read_data2_ID_EX, flush,
        output stall, md_busy, md_done, md_result, md_result_valid, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU run as 32-step radix-2
//   iterative sequences beside the pipeline; MFHI/MFLO/MTHI/MTLO complete
//   in the EX cycle. Later HI/LO ops stall while an operation is in flight.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     md   ex_muldiv_unit_if.slave (operands, flush, stall, results, HI/LO)
module ex_muldiv_unit #(
    parameter int         XLEN    = 32,
    parameter logic [5:0] F_MULT  = 6'h18,
    parameter logic [5:0] F_MULTU = 6'h19,
    parameter logic [5:0] F_DIV   = 6'h1A,
    parameter logic [5:0] F_DIVU  = 6'h1B,
    parameter logic [5:0] F_MFHI  = 6'h10,
    parameter logic [5:0] F_MTHI  = 6'h11,
    parameter logic [5:0] F_MFLO  = 6'h12,
    parameter logic [5:0] F_MTLO  = 6'h13
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_unit_if.slave md
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     opa_q, opa_d, opb_q, opb_d;
    // MUL: 64-bit partial product. DIV: {remainder, quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;

    logic [5:0]          funct;
    logic [XLEN-1:0]     rs, rt;
    logic                is_md, accept, signed_op;
    logic [XLEN:0]       div_trial, div_diff;
    logic                div_ge;
    logic [XLEN-1:0]     rem_next;

    function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic sgn);
        if (sgn && v[XLEN-1]) return XLEN'(-v);
        return v;
    endfunction

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    assign funct     = md.funct_ID_EX;
    assign rs        = md.read_data1_ID_EX;
    assign rt        = md.read_data2_ID_EX;
    assign is_md     = md.md_valid &&
                       (funct == F_MULT || funct == F_MULTU || funct == F_DIV  || funct == F_DIVU ||
                        funct == F_MFHI || funct == F_MTHI  || funct == F_MFLO || funct == F_MTLO);
    assign accept    = is_md && !md.flush && (state_q == S_IDLE);
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);

    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits.
    assign div_trial = {acc_q[2*XLEN-1:XLEN], opa_q[cnt_q]};
    assign div_diff  = div_trial - {1'b0, opb_q};
    assign div_ge    = div_trial >= {1'b0, opb_q};
    assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (funct == F_MULT || funct == F_MULTU) begin
                        opa_d    = mag(rs, signed_op);
                        opb_d    = mag(rt, signed_op);
                        neg_d    = signed_op && (rs[XLEN-1] ^ rt[XLEN-1]);
                        rneg_d   = 1'b0;
                        is_div_d = 1'b0;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(XLEN-1);
                        state_d  = S_MUL;
                    end else if (funct == F_DIV || funct == F_DIVU) begin
                        is_div_d = 1'b1;
                        if (rt == '0) begin
                            // Divide by zero: result is fixed; FIX rewrites
                            // the same values with no sign correction.
                            hi_d    = rs;
                            lo_d    = '1;
                            acc_d   = {rs, {XLEN{1'b1}}};
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = S_FIX;
                        end else begin
                            opa_d   = mag(rs, signed_op);
                            opb_d   = mag(rt, signed_op);
                            neg_d   = signed_op && (rs[XLEN-1] ^ rt[XLEN-1]);
                            rneg_d  = signed_op && rs[XLEN-1];
                            acc_d   = '0;
                            cnt_d   = CNT_W'(XLEN-1);
                            state_d = S_DIV;
                        end
                    end else if (funct == F_MTHI) begin
                        hi_d = rs;
                    end else if (funct == F_MTLO) begin
                        lo_d = rs;
                    end
                end
            end
            S_MUL: begin
                // MSB-first shift-add over the multiplier bits
                acc_d = {acc_q[2*XLEN-2:0], 1'b0} +
                        (opb_q[cnt_q] ? {{XLEN{1'b0}}, opa_q} : {2*XLEN{1'b0}});
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {rem_next, acc_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = neg_w(acc_q[2*XLEN-1:XLEN], rneg_q);
                    lo_d = neg_w(acc_q[XLEN-1:0], neg_q);
                end else begin
                    {hi_d, lo_d} = neg_dw(acc_q, neg_q);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand/working registers are only meaningful while the FSM is active.
    always_ff @(posedge clk) begin
        opa_q    <= opa_d;
        opb_q    <= opb_d;
        acc_q    <= acc_d;
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
    end

    assign md.stall           = is_md && !md.flush && (state_q != S_IDLE);
    assign md.md_busy         = (state_q != S_IDLE);
    assign md.md_done         = done_q;
    assign md.md_result_valid = accept && (funct == F_MFHI || funct == F_MFLO);
    assign md.md_result       = !accept           ? '0   :
                                (funct == F_MFHI) ? hi_q :
                                (funct == F_MFLO) ? lo_q : '0;
    assign md.hi_out          = hi_q;
    assign md.lo_out          = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] hi_m, lo_m;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();
    ex_muldiv_unit dut (.clk(clk), .rst(rst), .md(bus));

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the architectural definitions.
    function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (f)
            F_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            F_MULTU: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            F_DIV: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.md_valid         = 1'b0;
        bus.funct_ID_EX      = 6'h00;
        bus.read_data1_ID_EX = 32'h0;
        bus.read_data2_ID_EX = 32'h0;
        bus.flush            = 1'b0;
    endtask

    // Issue one mul/div op and wait (bounded) for md_done.
    // lat counts cycles after the accept cycle; -1 means it never came.
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo);
        bus.md_valid         = 1'b1;
        bus.funct_ID_EX      = f;
        bus.read_data1_ID_EX = a;
        bus.read_data2_ID_EX = b;
        bus.flush            = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        lat = -1;
        hi  = '0;
        lo  = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.md_done) begin
                lat = i;
                hi  = bus.hi_out;
                lo  = bus.lo_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        n_vec++; if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.md_busy); end
        n_vec++; if (bus.md_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.md_done); end
        n_vec++; if (bus.md_result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", bus.md_result); end
        n_vec++; if (bus.md_result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b exp 0", bus.md_result_valid); end
        n_vec++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h exp 0", bus.hi_out); end
        n_vec++; if (bus.lo_out !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h exp 0", bus.lo_out); end
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic test_mult();
        int lat;
        logic [31:0] hi, lo;
        run_md(F_MULT, 32'hFFFFFFFD, 32'd5, lat, hi, lo);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL mult_latency got %0d exp 34", lat); end
        n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
        run_md(F_MULTU, 32'hFFFFFFFD, 32'd5, lat, hi, lo);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL multu_latency got %0d exp 34", lat); end
        n_vec++; if (hi !== 32'h00000004) begin n_err++; $display("FAIL multu_hi got %h exp 00000004", hi); end
        n_vec++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL multu_lo got %h exp fffffff1", lo); end
    endtask

    task automatic test_div();
        int lat;
        logic [31:0] hi, lo;
        run_md(F_DIVU, 32'd100, 32'd7, lat, hi, lo);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL divu_latency got %0d exp 34", lat); end
        n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
        n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h exp 00000002", hi); end
        run_md(F_DIV, 32'hFFFFFFF9, 32'd2, lat, hi, lo);
        n_vec++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo got %h exp fffffffd", lo); end
        n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi got %h exp ffffffff", hi); end
        run_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, hi, lo);
        n_vec++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
    endtask

    task automatic test_divzero();
        int lat;
        logic [31:0] hi, lo;
        run_md(F_DIV, 32'd9, 32'd0, lat, hi, lo);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL divz_latency got %0d exp 2", lat); end
        n_vec++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
        n_vec++; if (hi !== 32'd9) begin n_err++; $display("FAIL divz_hi got %h exp 00000009", hi); end
        hi_m = 32'd9;
        lo_m = 32'hFFFFFFFF;
    endtask

    task automatic test_stall_mflo();
        int stalls;
        logic rv_during_stall;
        bus.md_valid         = 1'b1;
        bus.funct_ID_EX      = F_MULT;
        bus.read_data1_ID_EX = 32'd6;
        bus.read_data2_ID_EX = 32'd7;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.md_busy !== 1'b1) begin n_err++; $display("FAIL busy_inflight got %b exp 1", bus.md_busy); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL nostall_bubble got %b exp 0", bus.stall); end
        @(posedge clk); #1;
        bus.md_valid    = 1'b1;
        bus.funct_ID_EX = F_MFLO;
        stalls = 0;
        rv_during_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.stall !== 1'b1) break;
            if (bus.md_result_valid !== 1'b0) rv_during_stall = 1'b1;
            stalls++;
            @(posedge clk); #1;
        end
        n_vec++; if (stalls !== 32) begin n_err++; $display("FAIL stall_cycles got %0d exp 32", stalls); end
        n_vec++; if (rv_during_stall !== 1'b0) begin n_err++; $display("FAIL rvalid_while_stalled got %b exp 0", rv_during_stall); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_release got %b exp 0", bus.stall); end
        n_vec++; if (bus.md_result !== 32'd42) begin n_err++; $display("FAIL mflo_result got %h exp 0000002a", bus.md_result); end
        n_vec++; if (bus.md_result_valid !== 1'b1) begin n_err++; $display("FAIL mflo_rvalid got %b exp 1", bus.md_result_valid); end
        n_vec++; if (bus.md_done !== 1'b1) begin n_err++; $display("FAIL mflo_done got %b exp 1", bus.md_done); end
        @(posedge clk); #1;
        idle_inputs();
        hi_m = 32'd0;
        lo_m = 32'd42;
    endtask

    task automatic test_mthi_flush();
        logic [31:0] v;
        bus.md_valid         = 1'b1;
        bus.funct_ID_EX      = F_MTHI;
        bus.read_data1_ID_EX = 32'h1234;
        @(posedge clk); #1;
        bus.funct_ID_EX      = F_MFHI;
        bus.read_data1_ID_EX = 32'h0;
        @(negedge clk);
        n_vec++; if (bus.md_result !== 32'h1234) begin n_err++; $display("FAIL mfhi_result got %h exp 00001234", bus.md_result); end
        n_vec++; if (bus.md_result_valid !== 1'b1) begin n_err++; $display("FAIL mfhi_rvalid got %b exp 1", bus.md_result_valid); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mfhi_stall got %b exp 0", bus.stall); end
        hi_m = 32'h1234;
        @(posedge clk); #1;
        v = $urandom | 32'h1;
        bus.funct_ID_EX      = F_MTLO;
        bus.read_data1_ID_EX = v;
        bus.flush            = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.md_result_valid !== 1'b0) begin n_err++; $display("FAIL flush_rvalid got %b exp 0", bus.md_result_valid); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.lo_out !== lo_m) begin n_err++; $display("FAIL flush_mtlo_lo got %h exp %h", bus.lo_out, lo_m); end
        n_vec++; if (bus.hi_out !== hi_m) begin n_err++; $display("FAIL flush_mtlo_hi got %h exp %h", bus.hi_out, hi_m); end
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        logic [31:0] hi, lo;
        bus.md_valid         = 1'b1;
        bus.funct_ID_EX      = F_DIVU;
        bus.read_data1_ID_EX = $urandom;
        bus.read_data2_ID_EX = $urandom | 32'h1;
        @(posedge clk); #1;
        idle_inputs();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", bus.md_busy); end
        n_vec++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got %h exp 0", bus.hi_out); end
        n_vec++; if (bus.lo_out !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got %h exp 0", bus.lo_out); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.md_done === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL rstmid_done_pulses got %0d exp 0", dones); end
        run_md(F_MULT, 32'd3, 32'd3, lat, hi, lo);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL rstmid_mult_latency got %0d exp 34", lat); end
        n_vec++; if (lo !== 32'd9) begin n_err++; $display("FAIL rstmid_mult_lo got %h exp 00000009", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rstmid_mult_hi got %h exp 0", hi); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [4];
        logic [5:0]  f;
        logic [31:0] a, b, eh, el, hi, lo;
        int          lat, exp_lat, sel;
        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
        for (int n = 0; n < 24; n++) begin
            f   = ops[$urandom_range(0, 3)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) a = $urandom_range(0, 255);
            ref_md(f, a, b, eh, el);
            exp_lat = ((f == F_DIV || f == F_DIVU) && b == 0) ? 2 : 34;
            run_md(f, a, b, lat, hi, lo);
            n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd_latency f=%h a=%h b=%h got %0d exp %0d", f, a, b, lat, exp_lat); end
            n_vec++; if (hi !== eh) begin n_err++; $display("FAIL rnd_hi f=%h a=%h b=%h got %h exp %h", f, a, b, hi, eh); end
            n_vec++; if (lo !== el) begin n_err++; $display("FAIL rnd_lo f=%h a=%h b=%h got %h exp %h", f, a, b, lo, el); end
            bus.md_valid    = 1'b1;
            bus.funct_ID_EX = (n % 2 == 0) ? F_MFHI : F_MFLO;
            @(negedge clk);
            n_vec++; if (bus.md_result !== ((n % 2 == 0) ? eh : el)) begin
                n_err++; $display("FAIL rnd_mf_result got %h exp %h", bus.md_result, (n % 2 == 0) ? eh : el);
            end
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_stall_mflo();
        test_mthi_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
